// File: rtl/demux1_to_2_ctrl.sv
// Dispatch controller for a 1-to-2 demux: steers a valid/ready word stream into two 1-deep lane registers.
// Optional per-lane saturating dispatch counters are built when DEMUX_CTRL_STATS_EN is defined.
module demux1_to_2_ctrl #(
  parameter int N     = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  input  logic             in_force,
  input  logic             in_lane,
  output logic             lane_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [N-1:0]     out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [N-1:0]     out1_data,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {PREF0 = 1'b0, PREF1 = 1'b1} rr_e;

  rr_e          rr_q, rr_d;
  logic         out0_valid_q, out0_valid_d;
  logic         out1_valid_q, out1_valid_d;
  logic [N-1:0] out0_data_q, out0_data_d;
  logic [N-1:0] out1_data_q, out1_data_d;

  logic free0, free1, rr_bit, free_rr, accept, load0, load1;

  // NOTE: every signal written here gets a value on every path first, so no latches are inferred.
  always_comb begin
    free0        = !out0_valid_q | out0_ready;
    free1        = !out1_valid_q | out1_ready;
    rr_bit       = (rr_q == PREF1);
    free_rr      = rr_bit ? free1 : free0;
    // in_ready never looks at in_valid, so a source may wait on it without a loop.
    in_ready     = in_force ? (in_lane ? free1 : free0) : (free0 | free1);
    lane_sel     = in_force ? in_lane : (free_rr ? rr_bit : ~rr_bit);
    accept       = in_valid & in_ready;
    load0        = accept & ~lane_sel;
    load1        = accept &  lane_sel;
    rr_d         = accept ? rr_e'(~lane_sel) : rr_q;
    out0_valid_d = load0 | (out0_valid_q & ~out0_ready);
    out1_valid_d = load1 | (out1_valid_q & ~out1_ready);
    out0_data_d  = load0 ? in_data : out0_data_q;
    out1_data_d  = load1 ? in_data : out1_data_q;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q         <= PREF0;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
    end else begin
      rr_q         <= rr_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;

`ifdef DEMUX_CTRL_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    cnt0_d = (load0 && (cnt0_q != '1)) ? cnt0_q + CNT_W'(1) : cnt0_q;
    cnt1_d = (load1 && (cnt1_q != '1)) ? cnt1_q + CNT_W'(1) : cnt1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign cnt0 = cnt0_q;
  assign cnt1 = cnt1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
